result_writeback: RTL
=====================

// Module: result_writeback
// PURPOSE
// - Downstream of the array results controller. Consumes its result beats (data/valid, no backpressure
//   upstream) and turns them into addressed memory writes of result matrix C (m x p, row-major) at base_addr.
// - A FIFO absorbs the mismatch between a stalling memory port and the never-stalling result stream.
// - Signals done after the final beat of C has been written to memory.
// PARAMETERS
// - ARRAY_HEIGHT  4    rows per tile; result lanes per tile
// - ARRAY_WIDTH   32   columns per tile
// - DATA_WIDTH    16   bits per element
// - BUS_WIDTH     256  bits per beat; E = BUS_WIDTH/DATA_WIDTH elements per beat
// - ADDR_WIDTH    32   byte-address width
// - FIFO_DEPTH    8    beat buffer depth; power of 2, >= 2
// PORTS
// - clk           in   1           single clock; everything on posedge
// - reset         in   1           synchronous, active-high
// - start         in   1           1-cycle pulse: latch m, p, base_addr; IDLE->RUN
// - m             in   16          rows of C; multiple of ARRAY_HEIGHT, >= ARRAY_HEIGHT
// - p             in   16          columns of C; multiple of ARRAY_WIDTH, >= ARRAY_WIDTH
// - base_addr     in   ADDR_WIDTH  byte address of C[0][0]
// - data_i        in   BUS_WIDTH   result beat; element k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
// - valid_i       in   1           beat present; always accepted (no ready upstream)
// - mem_addr_o    out  ADDR_WIDTH  byte address of the beat's first element
// - mem_data_o    out  BUS_WIDTH   beat payload, unchanged
// - mem_valid_o   out  1           write request
// - mem_ready_i   in   1           write accepted when mem_valid_o & mem_ready_i
// - busy_o        out  1           state == RUN
// - done_o        out  1           1-cycle pulse after the last write handshake
// - err_o         out  1           sticky: beat lost (push while full, or valid_i while IDLE)
// BEHAVIOUR
// - Reset: state IDLE, FIFO empty, all counters 0.
//   - Outputs: mem_valid_o=0, mem_addr_o=0, mem_data_o=0, busy_o=0, done_o=0, err_o=0.
// - FSM: IDLE -start-> RUN -last pop handshake-> DONE -(1 cycle)-> IDLE.
//   - start outside IDLE is ignored.
//   - start in IDLE clears err_o.
// - Push: valid_i in RUN writes data_i to the FIFO.
//   - If full with no pop in the same cycle: beat dropped, err_o<=1.
//   - Full with a same-cycle pop: push is legal.
//   - valid_i in IDLE/DONE: dropped, err_o<=1.
// - Pop: mem_valid_o = FIFO not empty; pop on mem_valid_o & mem_ready_i.
//   - No bypass: a beat pushed at edge t is first visible on mem_*_o in the cycle after edge t.
//   - mem_addr_o/mem_data_o hold stable while mem_valid_o & ~mem_ready_i.
// - Beat order (pop side): beat b (inner, 0..ARRAY_WIDTH/E-1), lane l (0..ARRAY_HEIGHT-1),
//   column tile tc (step ARRAY_WIDTH, < p), row tile tr (outer, step ARRAY_HEIGHT, < m).
// - Address: mem_addr_o = base_addr + ((tr+l)*p + tc + b*E) * (DATA_WIDTH/8).
//   - Row product is 32-bit; result truncated to ADDR_WIDTH; wrap-around is not flagged.
// - Last beat: b, l, tc, tr all at their maxima; its handshake moves to DONE.
//   - All counters reset to 0; done_o=1 for exactly that one DONE cycle.
//   - Total beats = m*p/E.
// - Beats arriving after the last expected push are treated as IDLE beats (err_o).
// - reset mid-operation: FIFO flushed, counters cleared, IDLE next cycle; in-flight beats discarded.
// TESTING (H=2, W=4, DATA_WIDTH=16, BUS_WIDTH=64 so E=4, FIFO_DEPTH=4, base=0x1000, ready=1 unless noted)
// - m=2, p=4; 2 beats -> addrs 0x1000, 0x1008.
//   - done_o pulses 1 cycle after the 2nd handshake; err_o=0.
// - m=4, p=8; 8 beats -> addrs 0x1000, 0x1010, 0x1008, 0x1018, 0x1020, 0x1030, 0x1028, 0x1038;
//   data matches push order.
// - m=2, p=4 with ready=0 during the 2 pushes -> mem_valid_o=1 holding 0x1000 and beat 0 stable;
//   ready=1 -> both drain in order.
// - ready=0, 5 back-to-back beats into depth-4 FIFO -> 5th dropped, err_o=1 stays set.
//   - Next start clears err_o.
// - valid_i pulse while IDLE -> no mem_valid_o, err_o=1.
//   - start in RUN -> ignored, addresses unchanged.
// - reset asserted after 3 of 8 pushes -> next cycle IDLE, mem_valid_o=0.
//   - Fresh start with m=2, p=4 then gives 0x1000, 0x1008.

Source files
------------

// File: rtl/result_writeback.sv
// Result writeback: buffers result beats from the array controller and writes
// matrix C row-major to memory, tile by tile, with done/err status.
module result_writeback #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int BUS_WIDTH    = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           m,
    input  logic [15:0]           p,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [BUS_WIDTH-1:0]  data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [BUS_WIDTH-1:0]  mem_data_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int E     = BUS_WIDTH / DATA_WIDTH;
    localparam int BPR   = ARRAY_WIDTH / E;
    localparam int BW    = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int LW    = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [15:0]             m_r, p_r;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [31:0]             total_r, push_cnt_r;
    logic [BW-1:0]           b_r, b_s;
    logic [LW-1:0]           l_r, l_s;
    logic [15:0]             tc_r, tc_s, tr_r, tr_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [BUS_WIDTH-1:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]           count_r;
    logic                    err_r;

    logic start_s, empty_s, full_s, pop_s, push_s, drop_s;
    logic tc_last_s, tr_last_s, last_s;

    function automatic logic [ADDR_WIDTH-1:0] addr_of(
        input logic [15:0]           tr,
        input logic [LW-1:0]         l,
        input logic [15:0]           tc,
        input logic [BW-1:0]         b,
        input logic [15:0]           cols,
        input logic [ADDR_WIDTH-1:0] base
    );
        logic [31:0] row;
        logic [31:0] elem;
        row  = (32'(tr) + 32'(l)) * 32'(cols);
        elem = row + 32'(tc) + 32'(b) * 32'(E);
        return base + ADDR_WIDTH'(elem * 32'(BYTES));
    endfunction

    // Handshake and boundary flags
    always_comb begin
        start_s   = start & (state_r == IDLE);
        empty_s   = (count_r == CW'(0));
        full_s    = (count_r == CW'(FIFO_DEPTH));
        pop_s     = ~empty_s & mem_ready_i;
        tc_last_s = (({1'b0, tc_r} + 17'(ARRAY_WIDTH)) >= {1'b0, p_r});
        tr_last_s = (({1'b0, tr_r} + 17'(ARRAY_HEIGHT)) >= {1'b0, m_r});
        last_s    = (b_r == BW'(BPR - 1)) & (l_r == LW'(ARRAY_HEIGHT - 1)) &
                    tc_last_s & tr_last_s;
        // A full FIFO still takes a beat when the head leaves in the same cycle
        push_s    = valid_i & (state_r == RUN) & (push_cnt_r < total_r) &
                    (~full_s | pop_s);
        drop_s    = valid_i & ~push_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (pop_s & last_s) state_s = DONE;
                else                state_s = RUN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Pop-side tile walk: beat, lane, column tile, row tile
    always_comb begin
        b_s  = b_r;
        l_s  = l_r;
        tc_s = tc_r;
        tr_s = tr_r;
        if (b_r == BW'(BPR - 1)) begin
            b_s = BW'(0);
            if (l_r == LW'(ARRAY_HEIGHT - 1)) begin
                l_s = LW'(0);
                if (tc_last_s) begin
                    tc_s = 16'd0;
                    tr_s = tr_r + 16'(ARRAY_HEIGHT);
                end else begin
                    tc_s = tc_r + 16'(ARRAY_WIDTH);
                end
            end else begin
                l_s = l_r + LW'(1);
            end
        end else begin
            b_s = b_r + BW'(1);
        end
    end

    // Job configuration latched at start
    always_ff @(posedge clk) begin
        if (reset) begin
            m_r     <= 16'd0;
            p_r     <= 16'd0;
            base_r  <= '0;
            total_r <= 32'd0;
        end else if (start_s) begin
            m_r     <= m;
            p_r     <= p;
            base_r  <= base_addr;
            total_r <= (32'(m) * 32'(p)) / 32'(E);
        end
    end

    // Walk counters and registered write address of the FIFO head
    always_ff @(posedge clk) begin
        if (reset) begin
            b_r    <= BW'(0);
            l_r    <= LW'(0);
            tc_r   <= 16'd0;
            tr_r   <= 16'd0;
            addr_r <= '0;
        end else if (start_s) begin
            b_r    <= BW'(0);
            l_r    <= LW'(0);
            tc_r   <= 16'd0;
            tr_r   <= 16'd0;
            addr_r <= base_addr;
        end else if (pop_s & (state_r == RUN)) begin
            if (last_s) begin
                b_r    <= BW'(0);
                l_r    <= LW'(0);
                tc_r   <= 16'd0;
                tr_r   <= 16'd0;
                addr_r <= '0;
            end else begin
                b_r    <= b_s;
                l_r    <= l_s;
                tc_r   <= tc_s;
                tr_r   <= tr_s;
                addr_r <= addr_of(tr_s, l_s, tc_s, b_s, p_r, base_r);
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            if (push_s & ~pop_s)      count_r <= count_r + CW'(1);
            else if (pop_s & ~push_s) count_r <= count_r - CW'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= data_i;
    end

    // Accepted-push count and sticky beat-loss flag
    always_ff @(posedge clk) begin
        if (reset) begin
            push_cnt_r <= 32'd0;
            err_r      <= 1'b0;
        end else begin
            if (start_s | (pop_s & last_s & (state_r == RUN))) push_cnt_r <= 32'd0;
            else if (push_s)                                    push_cnt_r <= push_cnt_r + 32'd1;
            if (start_s) err_r <= drop_s;
            else         err_r <= err_r | drop_s;
        end
    end

    // Head payload, zero while the FIFO is empty
    always_comb begin
        if (empty_s) mem_data_o = '0;
        else         mem_data_o = fifo_mem_r[rd_ptr_r];
    end

    assign mem_addr_o  = addr_r;
    assign mem_valid_o = ~empty_s;
    assign busy_o      = (state_r == RUN);
    assign done_o      = (state_r == DONE);
    assign err_o       = err_r;

endmodule
